// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide,
// one bit per clock, with start/busy/valid handshake and single-cycle bypass cases.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q, rneg_q;
  logic [XLEN-1:0]   opnd;   // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0] acc;    // {product high, multiplier} or {unused, dividend/quotient}
  logic [XLEN-1:0]   rem;

  // Operand decode at accept
  logic            is_div, a_signed, b_signed, a_neg, b_neg, div_zero, ovf, accept, last;
  logic [XLEN-1:0] a_abs, b_abs;

  always_comb begin
    is_div   = op[2];
    // MUL low half is sign-agnostic, so it runs unsigned
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed && rs1[XLEN-1];
    b_neg    = b_signed && rs2[XLEN-1];
    a_abs    = a_neg ? -rs1 : rs1;
    b_abs    = b_neg ? -rs2 : rs2;
    div_zero = is_div && (rs2 == '0);
    ovf      = ((op == 3'b100) || (op == 3'b110)) &&
               (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    accept   = (state == IDLE) && start && !flush;
    last     = (state == CALC) && (cnt == CW'(XLEN-1));
  end

  // One iteration step for each operation
  logic [XLEN:0]     mul_sum, shifted, trial;
  logic [2*XLEN-1:0] mul_nxt, prod_fix;
  logic [XLEN-1:0]   quo_nxt, rem_nxt, quo_fix, rem_fix, fin;
  logic              div_ok;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    shifted  = {rem, acc[XLEN-1]};
    trial    = shifted - {1'b0, opnd};
    div_ok   = !trial[XLEN];
    rem_nxt  = div_ok ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt  = {acc[XLEN-2:0], div_ok};
    prod_fix = neg_q ? -mul_nxt : mul_nxt;
    quo_fix  = neg_q ? -quo_nxt : quo_nxt;
    rem_fix  = rneg_q ? -rem_nxt : rem_nxt;
    case (op_q)
      3'b000:                 fin = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin = quo_fix;
      default:                fin = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (div_zero || ovf) ? DONE : CALC;
      CALC: if (flush) state_nxt = IDLE;
            else if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      rem    <= '0;
      result <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_q   <= op;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      rem    <= '0;
      if (is_div) begin
        opnd <= b_abs;
        acc  <= {{XLEN{1'b0}}, a_abs};
      end else begin
        opnd <= a_abs;
        acc  <= {{XLEN{1'b0}}, b_abs};
      end
      // op[1] separates REM/REMU from DIV/DIVU
      if (div_zero)  result <= op[1] ? rs1 : '1;
      else if (ovf)  result <= op[1] ? '0 : rs1;
    end else if (state == CALC && !flush) begin
      cnt <= cnt + 1'b1;
      if (op_q[2]) begin
        acc <= {acc[2*XLEN-1:XLEN], quo_nxt};
        rem <= rem_nxt;
      end else begin
        acc <= mul_nxt;
      end
      if (last) result <= fin;
    end
  end

  assign busy  = (state != IDLE);
  assign valid = (state == DONE);

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at XLEN=32 and XLEN=8: results, latency,
// bypass cases, start-while-busy, flush and asynchronous reset.
module tb_muldiv_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, flush, busy, valid;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, result;
  logic        start8, flush8, busy8, valid8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, result8;

  int checks = 0;
  int errors = 0;

  muldiv_iter #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy), .valid(valid), .result(result));

  muldiv_iter #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .flush(flush8), .op(op8),
    .rs1(a8), .rs2(b8), .busy(busy8), .valid(valid8), .result(result8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one op, optionally hammer start while busy, then check latency/result.
  task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit noise);
    int n;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 3'b101;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (noise && valid !== 1'b1) begin
        start = n[0]; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
      end
    end
    start = 1'b0;
    check({tag, "_lat"}, n + 1, lat);
    check({tag, "_res"}, result, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {30'd0, valid, busy}, 32'd0);
  endtask

  task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp, input int lat);
    int n;
    @(negedge clk);
    op8 = o; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (valid8 !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n + 1, lat);
    check({tag, "_res"}, {24'd0, result8}, {24'd0, exp});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, valid8}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    #2;
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_valid",  {31'd0, valid}, 32'd0);
    check("rst_result", result,         32'd0);
    check("rst_result8", {24'd0, result8}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run32("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
    run32("mulh",   3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);
    run32("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
    run32("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
    run32("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
    run32("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
    run32("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
    run32("divu0",  3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
    run32("remu0",  3'b111, 32'd7,        32'd0,        32'd7,        1,  1'b0);
    run32("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run32("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,       1,  1'b0);
    run32("mul_noise", 3'b000, 32'd7,     32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1);

    // Flush at iteration 10 of a divide
    @(negedge clk);
    op = 3'b100; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check("flush_busy",   {31'd0, busy},  32'd0);
    check("flush_valid",  {31'd0, valid}, 32'd0);
    check("flush_result", result,         32'hFFFFFFEB);
    @(negedge clk); flush = 1'b0;
    @(posedge clk); #1;
    check("flush_valid2", {31'd0, valid}, 32'd0);

    // Asynchronous reset mid-CALC, between clock edges
    @(negedge clk);
    op = 3'b000; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   {31'd0, busy},  32'd0);
    check("arst_valid",  {31'd0, valid}, 32'd0);
    check("arst_result", result,         32'd0);
    @(negedge clk); rst_n = 1'b1;
    run32("div_after_rst", 3'b100, 32'd100, 32'd7, 32'd14, 33, 1'b0);

    run8("div8_ovf", 3'b100, 8'h80, 8'hFF, 8'h80, 1);
    run8("mul8",     3'b000, 8'h10, 8'h10, 8'h00, 9);
    run8("mulhu8",   3'b011, 8'h10, 8'h10, 8'h01, 9);
    run8("div8",     3'b100, 8'hF9, 8'h02, 8'hFD, 9);
    run8("rem8",     3'b110, 8'hF9, 8'h02, 8'hFF, 9);
    run8("remu8_0",  3'b111, 8'h05, 8'h00, 8'h05, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative, parametrised RISC-V M-extension execute unit. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over XLEN-bit operands, one bit per clock, with a start/busy/valid handshake. It sits beside the single-cycle ALU in the execute stage and is selected when the ALU control decoder flags an M-extension op; the pipeline stalls on `busy`. Division-by-zero and signed-overflow cases bypass the iteration and complete in one cycle.

## Interface
- `XLEN`, 32: operand/result width; even, ≥ 4.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `flush`  in  1  synchronous abort of any in-flight op.
- `op`  in  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`  in  XLEN  operand a (dividend / multiplicand).
- `rs2`  in  XLEN  operand b (divisor / multiplier).
- `busy`  out  1  high whenever state ≠ IDLE.
- `valid`  out  1  one-cycle pulse; `result` correct while high.
- `result`  out  XLEN  registered result; held until the next accepted op.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE; `busy`=0, `valid`=0, `result`=0, iteration counter=0.
- IDLE: on `start`=1, latch `op`, signs, and magnitudes (|a| for signed a; |b| for signed b; MULHSU treats only a as signed; MULHU/DIVU/REMU treat both as unsigned).
  - Divide op with b=0: load `result` = all-ones (DIV/DIVU) or a (REM/REMU); go to DONE.
  - DIV/REM with a=2^(XLEN-1) and b=all-ones: `result` = a (DIV) or 0 (REM); go to DONE.
  - Otherwise: go to CALC with counter=0.
- CALC, multiply: shift-add over magnitudes into a 2·XLEN accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; remainder is XLEN+1 bits internally.
- On the XLEN-th CALC edge, write `result` and go to DONE. `result` takes:
  - MUL: low half of the product.
  - MULH/MULHSU/MULHU: high half of the product.
  - Quotient or remainder as selected by `op`.
- Sign fixup applies before the write:
  - Product is negated when the operand signs differ.
  - Quotient is negated when signs differ.
  - Remainder takes the sign of the dividend.
- DONE: `valid`=1 for this cycle only. Next edge → IDLE.
- `start` while `busy`=1 is ignored; no queuing.
- `flush`=1 in CALC or DONE: next edge → IDLE. `valid` stays 0 in the following cycle, and `result` keeps its previous value.
- `flush` has priority over `start` in the same cycle.
- `rst_n` low at any time: immediate IDLE with all outputs zero, regardless of the clock.
- Operand inputs may change after acceptance; the unit uses only latched copies.

## Timing
- Accept edge E0: the cycle in which `start`=1 and `busy`=0.
- Normal op: CALC iterations on edges E1..E_XLEN. `valid`=1 in the cycle after E_XLEN, so the latency is XLEN+1 edges. `busy`=1 from after E0 through the DONE cycle.
- Bypass op (div-by-zero, overflow): `valid`=1 in the cycle after E0, i.e. latency 1.
- Earliest back-to-back accept: the first cycle after DONE, when `busy`=0.
- Counter width is clog2(XLEN+1). It never wraps within an op and is cleared on every accept.
- `valid` and `busy` are registered outputs; neither depends combinationally on `start`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), XLEN=32 → `result`=0xFFFFFFEB with `valid` exactly 33 edges after accept. Check the MULH result on the same operands = 0xFFFFFFFF.
- Product high halves:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Signed divide rounding and bypass:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 7/0 → 0xFFFFFFFF and REMU 7/0 → 7, both with `valid` 1 edge after accept.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0, both with 1-cycle latency.
- `start` pulsed repeatedly mid-CALC: no effect on the in-flight result or timing. Then `flush` at iteration 10: `busy` drops next edge, no `valid`, and `result` is unchanged.
- `rst_n` asserted mid-CALC, asynchronous to `clk`: outputs zero immediately. After release, DIV 100/7 → 14 normally.
- Repeat the directed cases with XLEN=8, e.g. DIV 0x80/0xFF → 0x80 and MUL 0x10×0x10 → 0x00, to confirm parametrisation.
